ibex_ascon_state_writeback: RTL and testbench

IBEX_ASCON_STATE_WRITEBACK -- requirements
Module: ibex_ascon_state_writeback

---
 rtl/ibex_ascon_state_writeback.sv | 138 +++++++++++++
 tb/tb_ibex_ascon_state_writeback.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ascon_state_writeback.sv
// Streams a 320-bit Ascon state into ten GPRs over a valid/ready write port.
// Define ASCON_WB_ENDIAN_SWAP_EN to byte-reverse every written word.
module ibex_ascon_state_writeback #(
  parameter bit RV32E = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  input  logic         abort_i,
  output logic         wr_valid_o,
  input  logic         wr_ready_i,
  output logic [4:0]   wr_reg_num_o,
  output logic [31:0]  wr_val_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } st_e;

  st_e              state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0][31:0] snap_q, snap_d;
  logic [31:0]      word;
  logic [31:0]      word_out;
  logic [4:0]       reg_num;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Abort wins over everything; a handshake in the abort cycle still lands.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (abort_i) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            snap_d  = state_i;
            idx_d   = 4'd0;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (wr_ready_i) begin
            if (idx_q == 4'd9) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // Word 0 (x0.hi) lives in the top slice of the snapshot.
  always_comb begin
    word = snap_q[4'd9 - idx_q];
  end

`ifdef ASCON_WB_ENDIAN_SWAP_EN
  always_comb begin
    word_out = {word[7:0], word[15:8], word[23:16], word[31:24]};
  end
`else
  always_comb begin
    word_out = word;
  end
`endif

  always_comb begin
    reg_num = 5'd0;
    if (RV32E) begin
      case (idx_q)
        4'd0: reg_num = 5'd1;
        4'd1: reg_num = 5'd4;
        4'd2: reg_num = 5'd5;
        4'd3: reg_num = 5'd6;
        4'd4: reg_num = 5'd7;
        4'd5: reg_num = 5'd8;
        4'd6: reg_num = 5'd12;
        4'd7: reg_num = 5'd13;
        4'd8: reg_num = 5'd14;
        4'd9: reg_num = 5'd15;
        default: reg_num = 5'd0;
      endcase
    end else begin
      case (idx_q)
        4'd0: reg_num = 5'd12;
        4'd1: reg_num = 5'd13;
        4'd2: reg_num = 5'd14;
        4'd3: reg_num = 5'd15;
        4'd4: reg_num = 5'd16;
        4'd5: reg_num = 5'd17;
        4'd6: reg_num = 5'd28;
        4'd7: reg_num = 5'd29;
        4'd8: reg_num = 5'd30;
        4'd9: reg_num = 5'd31;
        default: reg_num = 5'd0;
      endcase
    end
  end

  always_comb begin
    wr_valid_o   = (state_q == WRITE);
    wr_reg_num_o = wr_valid_o ? reg_num : 5'd0;
    wr_val_o     = wr_valid_o ? word_out : 32'd0;
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
  end

endmodule

// File: tb/tb_ibex_ascon_state_writeback.sv
// Bench for ibex_ascon_state_writeback: RV32 and RV32E instances side by side.
// Expected writes are queued at start and popped on every handshake.
module tb_ibex_ascon_state_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [319:0] st_in;
  logic         abort;
  logic         ready;

  logic        v_a, busy_a, done_a;
  logic [4:0]  r_a;
  logic [31:0] d_a;
  logic        v_e, busy_e, done_e;
  logic [4:0]  r_e;
  logic [31:0] d_e;

  always #5 clk = ~clk;

  ibex_ascon_state_writeback #(.RV32E(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .state_i(st_in),
    .abort_i(abort), .wr_valid_o(v_a), .wr_ready_i(ready),
    .wr_reg_num_o(r_a), .wr_val_o(d_a), .busy_o(busy_a), .done_o(done_a)
  );

  ibex_ascon_state_writeback #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .start_i(start), .state_i(st_in),
    .abort_i(abort), .wr_valid_o(v_e), .wr_ready_i(ready),
    .wr_reg_num_o(r_e), .wr_val_o(d_e), .busy_o(busy_e), .done_o(done_e)
  );

  typedef struct {
    int          k;
    logic [31:0] v;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    int          stall_at;
    int          stall_n;
    int          ign_at;
    int          exp_done;
  } vec_t;

  exp_t q[$];
  int   vecs = 0;
  int   miscompares = 0;
  int   m32[10]  = '{12, 13, 14, 15, 16, 17, 28, 29, 30, 31};
  int   m32e[10] = '{1, 4, 5, 6, 7, 8, 12, 13, 14, 15};

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] expv(input logic [31:0] w);
`ifdef ASCON_WB_ENDIAN_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [319:0] pack(input logic [31:0] b,
                                        input logic [31:0] s);
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[319-32*k -: 32] = b + s * k;
    return r;
  endfunction

  task automatic push_all(input logic [31:0] b, input logic [31:0] s);
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      e.k = k;
      e.v = b + s * k;
      q.push_back(e);
    end
  endtask

  // Scoreboard monitor plus hold-stability and zero-when-idle checks
  logic        held = 1'b0;
  logic [4:0]  hreg;
  logic [31:0] hval;
  always @(negedge clk) begin
    if (!rst) begin
      if (v_a && held) begin
        chk("hold_reg", r_a, hreg);
        chk("hold_val", d_a, hval);
      end
      if (v_a && ready) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("reg_rv32", r_a, m32[e.k]);
          chk("val_rv32", d_a, expv(e.v));
          chk("reg_rv32e", r_e, m32e[e.k]);
          chk("val_rv32e", d_e, expv(e.v));
        end
      end
      if (!v_a) chk("idle_zero", {r_a, d_a, r_e, d_e}, 0);
      held = v_a && !ready;
      hreg = r_a;
      hval = d_a;
    end
  end

  task automatic run_vec(input vec_t v);
    logic [319:0] s;
    int hs, stalled;
    bit got;
    s = pack(v.base, v.step);
    push_all(v.base, v.step);
    start = 1'b1;
    st_in = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    st_in = ~s;
    hs = 0;
    stalled = 0;
    got = 0;
    for (int c = 1; c <= 60; c++) begin
      ready = !(hs == v.stall_at && stalled < v.stall_n);
      if (!ready) stalled++;
      start = (c == v.ign_at);
      @(negedge clk);
      if (c == 1) chk("first_valid", {v_a, v_e, busy_a}, 3'b111);
      if (done_a) begin
        chk("done_cycle", c, v.exp_done);
        chk("done_rv32e", {done_e, v_a, busy_a}, 3'b101);
        chk("queue_empty", q.size(), 0);
        got = 1;
      end
      if (v_a && ready) hs++;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (got) break;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{32'h1000_0000, 32'd1, -1, 0, -1, 11};
    tbl[1] = '{32'h1000_0000, 32'd1, 4, 3, -1, 14};
    tbl[2] = '{32'hDEAD_BEEF, 32'h0101_0101, 0, 1, 3, 12};
    tbl[3] = '{32'h0123_4567, 32'h1111_1111, 9, 2, 11, 13};
    tbl[4] = '{32'h0000_0000, 32'd0, -1, 0, 5, 11};

    rst = 1'b1;
    start = 1'b0;
    st_in = '1;
    abort = 1'b0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {v_a, r_a, d_a, busy_a, done_a}, 0);
    chk("reset_e", {v_e, r_e, d_e, busy_e, done_e}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back table runs, each start in the cycle after done
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Abort while word 6 is presented
    push_all(32'hA000_0000, 32'd1);
    start = 1'b1;
    st_in = pack(32'hA000_0000, 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_word6", {v_a, r_a}, {1'b1, 5'd28});
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort", {busy_a, done_a, busy_e, done_e}, 0);
    end
    @(posedge clk);
    #1;
    run_vec('{32'hFFFF_FFFF, 32'd0, -1, 0, -1, 11});

    // Reset mid-write has priority over abort and start
    push_all(32'h5555_0000, 32'd3);
    start = 1'b1;
    st_in = pack(32'h5555_0000, 32'd3);
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_reset", {busy_a, done_a, v_a, busy_e, done_e}, 0);
    end
    @(posedge clk);
    #1;
    run_vec(tbl[2]);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
